bg_pixel_fifo: RTL and testbench

BG_PIXEL_FIFO -- requirements
Module: bg_pixel_fifo

---
 rtl/bg_pixel_fifo.sv | 122 ++++++++++++
 tb/tb_bg_pixel_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO: accepts 8-pixel tile rows from the fetcher and shifts one
// palette-mapped pixel out per T-cycle, discarding SCX fine-scroll pixels at line start.
module bg_pixel_fifo #(
    parameter int X_MAX = 160,
    parameter int DEPTH = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       tclk_in,
    input  logic       line_start_in,
    input  logic [2:0] scx_fine_in,
    input  logic [7:0] bgp_in,
    input  logic       bg_enable_in,
    input  logic       push_in,
    input  logic [7:0] tile_lo_in,
    input  logic [7:0] tile_hi_in,
    output logic       push_ready_out,
    output logic       pixel_valid_out,
    output logic [1:0] pixel_out,
    output logic [7:0] x_out,
    output logic       line_done_out,
    output logic [4:0] count_out
);

    typedef enum logic [1:0] {IDLE, DISCARD, SHIFT, DONE} state_t;

    state_t     state, state_next;
    logic [4:0] count, count_next;
    logic [7:0] x, x_next;
    logic [2:0] discard, discard_next;
    logic       pixel_valid_next, line_done_next;
    logic [1:0] pixel_next;

    logic [1:0] fifo      [DEPTH];
    logic [1:0] fifo_next [DEPTH];

    logic       active, push_ok, pop;
    logic [4:0] base;

    assign active         = (state == DISCARD) || (state == SHIFT);
    assign push_ready_out = active && (count <= 5'(DEPTH - 8));
    assign push_ok        = push_in && push_ready_out && !line_start_in;
    assign pop            = tclk_in && (count != 5'd0) && active && !line_start_in;
    assign base           = count - (pop ? 5'd1 : 5'd0);

    assign count_out = count;
    assign x_out     = x;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next       = state;
        count_next       = count;
        x_next           = x;
        discard_next     = discard;
        pixel_valid_next = 1'b0;
        line_done_next   = 1'b0;
        pixel_next       = 2'b00;

        if (line_start_in) begin
            count_next   = 5'd0;
            x_next       = 8'd0;
            discard_next = scx_fine_in;
            state_next   = (scx_fine_in != 3'd0) ? DISCARD : SHIFT;
        end else begin
            count_next = count + (push_ok ? 5'd8 : 5'd0) - (pop ? 5'd1 : 5'd0);
            if (pop) begin
                if (state == DISCARD) begin
                    discard_next = discard - 3'd1;
                    if (discard == 3'd1) state_next = SHIFT;
                end else begin
                    // Palette and enable are taken in the pop cycle, so mid-line writes apply forward only.
                    pixel_valid_next = 1'b1;
                    pixel_next       = bg_enable_in ? bgp_in[{fifo[0], 1'b0} +: 2] : 2'b00;
                    if (x == 8'(X_MAX - 1)) begin
                        x_next         = 8'd0;
                        line_done_next = 1'b1;
                        state_next     = DONE;
                    end else begin
                        x_next = x + 8'd1;
                    end
                end
            end
        end
    end

    // Storage: shift down on pop, then drop the new row in just above the surviving entries.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            fifo_next[j] = fifo[j];
            if (pop) fifo_next[j] = (j < DEPTH - 1) ? fifo[(j + 1) % DEPTH] : fifo[j];
            if (push_ok && (j >= int'(base)) && (j < int'(base) + 8))
                fifo_next[j] = {tile_hi_in[7 - (j - int'(base))], tile_lo_in[7 - (j - int'(base))]};
        end
    end

    // NOTE: pixel storage carries no reset; count alone defines which entries are live.
    always_ff @(posedge clk_in) begin
        for (int j = 0; j < DEPTH; j++) fifo[j] <= fifo_next[j];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            count           <= 5'd0;
            x               <= 8'd0;
            discard         <= 3'd0;
            pixel_valid_out <= 1'b0;
            pixel_out       <= 2'b00;
            line_done_out   <= 1'b0;
        end else begin
            state           <= state_next;
            count           <= count_next;
            x               <= x_next;
            discard         <= discard_next;
            pixel_valid_out <= pixel_valid_next;
            pixel_out       <= pixel_next;
            line_done_out   <= line_done_next;
        end
    end

endmodule

// File: tb/tb_bg_pixel_fifo.sv
// Self-checking bench for bg_pixel_fifo: directed line scenarios plus randomized
// data, palette and T-cycle patterns compared against a queue-based pixel model.
module tb_bg_pixel_fifo;
    localparam int X_MAX = 160;
    localparam int DEPTH = 16;

    typedef enum {M_IDLE, M_DISC, M_SHIFT, M_DONE} mode_t;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       tclk_in = 1'b0;
    logic       line_start_in = 1'b0;
    logic [2:0] scx_fine_in = 3'd0;
    logic [7:0] bgp_in = 8'hE4;
    logic       bg_enable_in = 1'b1;
    logic       push_in = 1'b0;
    logic [7:0] tile_lo_in = 8'h00;
    logic [7:0] tile_hi_in = 8'h00;
    logic       push_ready_out, pixel_valid_out, line_done_out;
    logic [1:0] pixel_out;
    logic [7:0] x_out;
    logic [4:0] count_out;

    bg_pixel_fifo #(.X_MAX(X_MAX), .DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .tclk_in(tclk_in), .line_start_in(line_start_in),
        .scx_fine_in(scx_fine_in), .bgp_in(bgp_in), .bg_enable_in(bg_enable_in),
        .push_in(push_in), .tile_lo_in(tile_lo_in), .tile_hi_in(tile_hi_in),
        .push_ready_out(push_ready_out), .pixel_valid_out(pixel_valid_out),
        .pixel_out(pixel_out), .x_out(x_out), .line_done_out(line_done_out),
        .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    int        checks = 0;
    int        errors = 0;
    bit [1:0]  q[$];
    mode_t     m_mode = M_IDLE;
    int        m_x = 0;
    int        m_disc = 0;
    bit        m_valid = 1'b0;
    bit        m_done = 1'b0;
    bit [1:0]  m_pix = 2'b00;
    bit [1:0]  seen[$];
    int        n_valid = 0;
    int        n_done = 0;
    int        n_nonzero = 0;
    int        pushed = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (q.size() <= DEPTH - 8) && (m_mode == M_DISC || m_mode == M_SHIFT);
    endfunction

    // Advance the model by one clk using the inputs currently applied.
    task automatic model_tick();
        bit       rdy;
        bit [1:0] p;
        rdy     = m_ready();
        m_valid = 1'b0;
        m_done  = 1'b0;
        m_pix   = 2'b00;
        if (!rst_in) begin
            q.delete();
            m_mode = M_IDLE;
            m_x    = 0;
            m_disc = 0;
        end else if (line_start_in) begin
            q.delete();
            m_x    = 0;
            m_disc = int'(scx_fine_in);
            m_mode = (scx_fine_in != 0) ? M_DISC : M_SHIFT;
        end else begin
            if (tclk_in && q.size() > 0 && (m_mode == M_DISC || m_mode == M_SHIFT)) begin
                p = q.pop_front();
                if (m_mode == M_DISC) begin
                    m_disc--;
                    if (m_disc == 0) m_mode = M_SHIFT;
                end else begin
                    m_valid = 1'b1;
                    m_pix   = bg_enable_in ? bgp_in[2*p +: 2] : 2'b00;
                    m_x++;
                    if (m_x == X_MAX) begin
                        m_x    = 0;
                        m_done = 1'b1;
                        m_mode = M_DONE;
                    end
                end
            end
            if (push_in && rdy)
                for (int i = 0; i < 8; i++) q.push_back({tile_hi_in[7-i], tile_lo_in[7-i]});
        end
    endtask

    task automatic compare();
        check("count", {3'b0, count_out}, 8'(q.size()));
        check("x", x_out, 8'(m_x));
        check("valid", {7'b0, pixel_valid_out}, {7'b0, m_valid});
        check("pixel", {6'b0, pixel_out}, {6'b0, m_pix});
        check("done", {7'b0, line_done_out}, {7'b0, m_done});
        check("ready", {7'b0, push_ready_out}, {7'b0, m_ready()});
        if (pixel_valid_out === 1'b1) begin
            seen.push_back(pixel_out);
            n_valid++;
            if (pixel_out !== 2'b00) n_nonzero++;
        end
        if (line_done_out === 1'b1) n_done++;
    endtask

    task automatic step();
        model_tick();
        @(posedge clk_in);
        #1;
        compare();
    endtask

    task automatic start_line(input logic [2:0] scx);
        scx_fine_in   = scx;
        line_start_in = 1'b1;
        push_in       = 1'b0;
        step();
        line_start_in = 1'b0;
        seen.delete();
        n_valid = 0;
        n_done  = 0;
        n_nonzero = 0;
    endtask

    initial begin
        // Reset state, then idle with pushes offered: nothing may be accepted.
        step();
        step();
        rst_in  = 1'b1;
        push_in = 1'b1;
        tclk_in = 1'b1;
        for (int c = 0; c < 5; c++) step();

        // Single row, no fine scroll: eight shade-1 pixels, x walking 0..8.
        bgp_in = 8'hE4;
        start_line(3'd0);
        tile_lo_in = 8'hFF; tile_hi_in = 8'h00; push_in = 1'b1;
        step();
        push_in = 1'b0;
        for (int c = 0; c < 12; c++) step();
        check("l035_pixels", 8'(n_valid), 8'd8);
        check("l035_x", x_out, 8'd8);
        for (int i = 0; i < 8 && i < seen.size(); i++) check("l035_shade", {6'b0, seen[i]}, 8'd1);

        // Fine scroll of 3: first three pops are silent.
        start_line(3'd3);
        tile_lo_in = 8'h0F; tile_hi_in = 8'hF0; push_in = 1'b1;
        step();
        push_in = 1'b0;
        for (int c = 0; c < 12; c++) step();
        check("l036_pixels", 8'(n_valid), 8'd5);
        for (int i = 0; i < 5 && i < seen.size(); i++)
            check("l036_shade", {6'b0, seen[i]}, (i == 0) ? 8'd2 : 8'd1);

        // Occupancy boundaries: push refused at 9, push+pop at 8 gives 15.
        start_line(3'd0);
        tclk_in = 1'b0; push_in = 1'b1;
        tile_lo_in = 8'h5A; tile_hi_in = 8'h3C;
        step();
        step();
        push_in = 1'b0; tclk_in = 1'b1;
        for (int c = 0; c < 7; c++) step();
        check("l037_at9", {3'b0, count_out}, 8'd9);
        push_in = 1'b1; tclk_in = 1'b0;
        step();
        check("l037_drop", {3'b0, count_out}, 8'd9);
        push_in = 1'b0; tclk_in = 1'b1;
        step();
        push_in = 1'b1;
        step();
        check("l037_pushpop", {3'b0, count_out}, 8'd15);

        // Full line, continuous feed with random data and mid-line palette changes.
        start_line(3'd0);
        tclk_in = 1'b1; push_in = 1'b1;
        for (int c = 0; c < 3000 && n_done == 0; c++) begin
            tile_lo_in = 8'($urandom);
            tile_hi_in = 8'($urandom);
            if (c % 13 == 0) bgp_in = 8'($urandom);
            step();
        end
        check("l038_done", 8'(n_done), 8'd1);
        check("l038_pixels", 8'(n_valid), 8'd160);
        for (int c = 0; c < 10; c++) step();
        check("l038_frozen_x", x_out, 8'd0);
        check("l038_no_ready", {7'b0, push_ready_out}, 8'd0);

        // Background disabled, random T-cycles, pushes and scroll.
        bg_enable_in = 1'b0;
        start_line(3'($urandom_range(1, 7)));
        for (int c = 0; c < 5000 && n_done == 0; c++) begin
            tclk_in    = 1'($urandom_range(0, 1));
            push_in    = ($urandom_range(0, 9) < 7);
            tile_lo_in = 8'($urandom);
            tile_hi_in = 8'($urandom);
            bgp_in     = 8'($urandom);
            step();
        end
        check("l039_done", 8'(n_done), 8'd1);
        check("l039_pixels", 8'(n_valid), 8'd160);
        check("l039_all_zero", 8'(n_nonzero), 8'd0);
        bg_enable_in = 1'b1;

        // Mid-line reset at x=50 with six pixels queued.
        start_line(3'd0);
        tclk_in = 1'b1;
        pushed  = 0;
        for (int c = 0; c < 500 && m_x < 50; c++) begin
            push_in    = (pushed < 7);
            tile_lo_in = 8'($urandom);
            tile_hi_in = 8'($urandom);
            if (push_in && m_ready()) pushed++;
            step();
        end
        tclk_in = 1'b0; push_in = 1'b0;
        check("l040_x50", x_out, 8'd50);
        check("l040_cnt6", {3'b0, count_out}, 8'd6);
        #3 rst_in = 1'b0;
        #1;
        check("l040_async_cnt", {3'b0, count_out}, 8'd0);
        check("l040_async_x", x_out, 8'd0);
        check("l040_async_ready", {7'b0, push_ready_out}, 8'd0);
        step();
        rst_in = 1'b1; tclk_in = 1'b1; push_in = 1'b1;
        n_valid = 0;
        for (int c = 0; c < 20; c++) step();
        check("l040_idle_silent", 8'(n_valid), 8'd0);
        start_line(3'd2);
        push_in = 1'b1;
        for (int c = 0; c < 20; c++) step();
        check("l040_resume", 8'(n_valid > 0), 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
